// File: rtl/sobel_stream_if.sv
// Valid/ready bundle for the Sobel filter: raster pixels in, gradients out.
// The master side feeds pixels and consumes results; the slave side is the filter.
interface sobel_stream_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COORD_WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_pixel;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH+2:0]  out_grad;
    logic [COORD_WIDTH-1:0] out_row;
    logic [COORD_WIDTH-1:0] out_col;

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_grad,
        input  out_row,
        input  out_col
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_grad,
        output out_row,
        output out_col
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// two pipeline stages produce |Gx|+|Gy| (or a threshold flag) per interior pixel.
module sobel_stream #(
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int COORD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH+2:0] threshold,
    sobel_stream_if.slave         bus,
    output logic                  busy,
    output logic                  done
);
    localparam int GW  = DATA_WIDTH + 4;
    localparam int MW  = DATA_WIDTH + 3;
    localparam int CIW = $clog2(IMG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   done_nxt;

    logic [COORD_WIDTH-1:0] in_row;
    logic [COORD_WIDTH-1:0] in_col;
    logic [CIW-1:0]         col_idx;
    logic                   mode_q;
    logic [MW-1:0]          thr_q;

    logic advance;
    logic accept;
    logic last_col;
    logic last_pix;
    logic win_ok;

    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

    // Only columns 1..2 of the last window are stored; column 0 of the next
    // window is the old column 1, so a third column of registers is never read.
    logic [DATA_WIDTH-1:0] win_p0  [3][2];
    logic [DATA_WIDTH-1:0] win_nxt [3][3];

    logic signed [GW-1:0]   gx_c;
    logic signed [GW-1:0]   gy_c;
    logic signed [GW-1:0]   gx_p1;
    logic signed [GW-1:0]   gy_p1;
    logic [COORD_WIDTH-1:0] row_p1;
    logic [COORD_WIDTH-1:0] col_p1;
    logic                   vld_p1;

    function automatic logic signed [GW-1:0] widen(input logic [DATA_WIDTH-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [MW-1:0] magnitude(input logic signed [GW-1:0] gx,
                                                input logic signed [GW-1:0] gy);
        logic [MW-1:0] ax;
        logic [MW-1:0] ay;
        ax = gx[GW-1] ? MW'(-gx) : MW'(gx);
        ay = gy[GW-1] ? MW'(-gy) : MW'(gy);
        return ax + ay;
    endfunction

    function automatic logic [MW-1:0] result_value(input logic          m,
                                                   input logic [MW-1:0] mag,
                                                   input logic [MW-1:0] thr);
        if (!m) begin
            return mag;
        end
        return (mag >= thr) ? '1 : '0;
    endfunction

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && (state == RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != IDLE);
    assign col_idx      = in_col[CIW-1:0];
    assign last_col     = (in_col == COORD_WIDTH'(IMG_WIDTH - 1));
    assign last_pix     = last_col && (in_row == COORD_WIDTH'(IMG_HEIGHT - 1));
    assign win_ok       = (in_row >= COORD_WIDTH'(2)) && (in_col >= COORD_WIDTH'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_pix) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Final result is either gone or handshaking this cycle.
                if (!vld_p1 && advance) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_row <= '0;
            in_col <= '0;
            mode_q <= 1'b0;
            thr_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_nxt;
            if (state == IDLE && start) begin
                in_row <= '0;
                in_col <= '0;
                mode_q <= mode;
                thr_q  <= threshold;
            end else if (accept) begin
                if (last_col) begin
                    in_col <= '0;
                    in_row <= in_row + COORD_WIDTH'(1);
                end else begin
                    in_col <= in_col + COORD_WIDTH'(1);
                end
            end
        end
    end

    // Stage 0: window assembled from stored columns, line buffers and the new pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win_p0[r][0];
            win_nxt[r][1] = win_p0[r][1];
        end
        win_nxt[0][2] = lb1[col_idx];
        win_nxt[1][2] = lb0[col_idx];
        win_nxt[2][2] = bus.in_pixel;
    end

    assign gx_c = (widen(win_nxt[0][2]) + (widen(win_nxt[1][2]) <<< 1) + widen(win_nxt[2][2]))
                - (widen(win_nxt[0][0]) + (widen(win_nxt[1][0]) <<< 1) + widen(win_nxt[2][0]));
    assign gy_c = (widen(win_nxt[2][0]) + (widen(win_nxt[2][1]) <<< 1) + widen(win_nxt[2][2]))
                - (widen(win_nxt[0][0]) + (widen(win_nxt[0][1]) <<< 1) + widen(win_nxt[0][2]));

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= bus.in_pixel;
            for (int r = 0; r < 3; r++) begin
                win_p0[r][0] <= win_nxt[r][1];
                win_p0[r][1] <= win_nxt[r][2];
            end
        end
        // Stage 1: gradients and centre coordinates.
        if (advance) begin
            gx_p1  <= gx_c;
            gy_p1  <= gy_c;
            row_p1 <= in_row - COORD_WIDTH'(1);
            col_p1 <= in_col - COORD_WIDTH'(1);
        end
    end

    // Stage 2: output register, held while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_grad  <= '0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else if (advance) begin
            vld_p1        <= accept && win_ok;
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.out_grad <= result_value(mode_q, magnitude(gx_p1, gy_p1), thr_q);
                bus.out_row  <= row_p1;
                bus.out_col  <= col_p1;
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream: hand-computed frames plus a 2-D reference
// convolution, with random stalls, input gaps and a mid-frame reset.
module tb_sobel_stream;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NR = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DW+2:0] threshold = '0;
    logic          busy;
    logic          done;

    sobel_stream_if #(.DATA_WIDTH(DW), .COORD_WIDTH(CW)) bus();

    sobel_stream #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .DATA_WIDTH(DW),
        .COORD_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .threshold(threshold),
        .bus(bus),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int frame [H][W];
    int res_grad [64];
    int res_row [64];
    int res_col [64];
    int n_res;
    int n_done;
    int acc22_cyc;
    int first_cyc;
    int tests = 0;
    int failed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_grad(int r, int c, int m, int thr);
        int gx, gy, mag;
        gx = (frame[r-1][c+1] + 2 * frame[r][c+1] + frame[r+1][c+1])
           - (frame[r-1][c-1] + 2 * frame[r][c-1] + frame[r+1][c-1]);
        gy = (frame[r+1][c-1] + 2 * frame[r+1][c] + frame[r+1][c+1])
           - (frame[r-1][c-1] + 2 * frame[r-1][c] + frame[r-1][c+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m == 0) return mag;
        return (mag >= thr) ? 2047 : 0;
    endfunction

    // Hand-derived values: 1/2 vertical edge, 3 isolated pixel at (3,3), else 0.
    function automatic int hand_value(int pattern, int r, int c);
        int dr, dc;
        dr = (r > 3) ? r - 3 : 3 - r;
        dc = (c > 3) ? c - 3 : 3 - c;
        case (pattern)
            1: return (c == 3 || c == 4) ? 1020 : 0;
            2: return (c == 3 || c == 4) ? 2047 : 0;
            3: return (dr == 0 && dc == 0) ? 0 : ((dr <= 1 && dc <= 1) ? 510 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic run_frame(input int fmode, input int fthr, input bit gaps,
                             input bit stall, input bit thr_change, input int pattern);
        int idx, dguard, cguard, pg, pr, pc, r, c;
        bit stalled;
        @(negedge clk);
        mode = fmode[0];
        threshold = 11'(fthr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_run", int'(busy), 1);
        n_res = 0;
        n_done = 0;
        acc22_cyc = -100;
        first_cyc = -1;
        fork
            begin
                idx = 0;
                dguard = 0;
                while (idx < W * H && dguard < 5000) begin
                    @(negedge clk);
                    if (thr_change && idx == 30) threshold = '0;
                    start = stall && (idx == 10);
                    bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    bus.in_pixel = 8'(frame[idx / W][idx % W]);
                    #2;
                    if (bus.in_valid && bus.in_ready) begin
                        if (idx == 2 * W + 2) acc22_cyc = cyc;
                        idx++;
                    end
                    dguard++;
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
                start = 1'b0;
            end
            begin
                cguard = 0;
                stalled = 1'b0;
                pg = 0; pr = 0; pc = 0;
                while (n_done == 0 && cguard < 3000) begin
                    @(negedge clk);
                    cguard++;
                    if (stalled) begin
                        check("hold_valid", int'(bus.out_valid), 1);
                        check("hold_grad", int'(bus.out_grad), pg);
                        check("hold_row", int'(bus.out_row), pr);
                        check("hold_col", int'(bus.out_col), pc);
                    end
                    if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
                    if (done) begin
                        n_done++;
                        check("done_with_valid", int'(bus.out_valid), 0);
                    end
                    bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                    #1;
                    if (bus.out_valid && !bus.out_ready) check("in_ready_stall", int'(bus.in_ready), 0);
                    stalled = bus.out_valid && !bus.out_ready;
                    pg = int'(bus.out_grad);
                    pr = int'(bus.out_row);
                    pc = int'(bus.out_col);
                    if (bus.out_valid && bus.out_ready) begin
                        if (n_res < 64) begin
                            res_grad[n_res] = pg;
                            res_row[n_res] = pr;
                            res_col[n_res] = pc;
                        end
                        n_res++;
                    end
                end
                if (cguard >= 3000) check("frame_timeout", 1, 0);
                bus.out_ready = 1'b1;
            end
        join
        check("result_count", n_res, NR);
        check("done_pulses", n_done, 1);
        check("busy_idle", int'(busy), 0);
        if (!gaps && !stall) check("latency", first_cyc - acc22_cyc, 2);
        for (int k = 0; k < n_res && k < NR; k++) begin
            r = 1 + k / (W - 2);
            c = 1 + k % (W - 2);
            check($sformatf("row[%0d]", k), res_row[k], r);
            check($sformatf("col[%0d]", k), res_col[k], c);
            check($sformatf("golden[%0d]", k), res_grad[k], ref_grad(r, c, fmode, fthr));
            if (pattern >= 0)
                check($sformatf("hand[%0d]", k), res_grad[k], hand_value(pattern, r, c));
        end
    endtask

    initial begin
        int acc, guard, dcount;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_grad", int'(bus.out_grad), 0);
        check("rst_out_row", int'(bus.out_row), 0);
        check("rst_out_col", int'(bus.out_col), 0);
        rst = 1'b1;

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 100;
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 0);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (c >= 4) ? 255 : 0;
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 1);
        run_frame(1, 500, 1'b0, 1'b0, 1'b1, 2);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = ((r + c) % 2) * 255;
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 0);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (r == 3 && c == 3) ? 255 : 0;
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 3);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
        run_frame(0, 0, 1'b1, 1'b1, 1'b0, -1);

        // Abort a frame after 20 accepted pixels.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        guard = 0;
        dcount = 0;
        while (acc < 20 && guard < 500) begin
            @(negedge clk);
            if (done) dcount++;
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(frame[acc / W][acc % W]);
            #2;
            if (bus.in_valid && bus.in_ready) acc++;
            guard++;
        end
        check("abort_accepts", acc, 20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(bus.in_ready), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_out_grad", int'(bus.out_grad), 0);
        check("abort_out_row", int'(bus.out_row), 0);
        check("abort_out_col", int'(bus.out_col), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        check("abort_idle", int'(busy), 0);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
